// File: rtl/sd_cmd_engine.sv
// sd_cmd_engine: SD-bus command-line engine.
//   Divides clk down to sd_clk, serialises a 48-bit command with its CRC7 on
//   sd_clk falling edges, then optionally receives an R48/R136 response on
//   sd_clk rising edges, checking CRC, end bit and index, with a timeout.
// Ports:
//   clk, rst_n            system clock, async active-low reset
//   clk_div               sd_clk half-period in clk cycles (0 behaves as 1)
//   start                 one-cycle request, taken only while idle
//   cmd_index/cmd_arg     command fields
//   resp_type             0 none, 1 R48 checked, 2 R48 unchecked, 3 R136
//   busy/done             transaction in progress / one-cycle completion pulse
//   resp_index/resp_data  received response fields
//   err_*                 timeout, CRC, end-bit and index errors
//   sd_clk, sd_cmd_out, sd_cmd_oe, sd_cmd_in   card-side pins
module sd_cmd_engine #(
    parameter int DIVW    = 8,
    parameter int NCR_MAX = 64,
    parameter int NCC     = 8
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [DIVW-1:0] clk_div,
    input  logic            start,
    input  logic [5:0]      cmd_index,
    input  logic [31:0]     cmd_arg,
    input  logic [1:0]      resp_type,
    output logic            busy,
    output logic            done,
    output logic [5:0]      resp_index,
    output logic [127:0]    resp_data,
    output logic            err_timeout,
    output logic            err_crc,
    output logic            err_end,
    output logic            err_index,
    output logic            sd_clk,
    output logic            sd_cmd_out,
    output logic            sd_cmd_oe,
    input  logic            sd_cmd_in
);

    localparam int NCR_W = $clog2(NCR_MAX + 1);
    localparam int GAP_W = $clog2(2 * NCC + 1);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_TX   = 3'd1,
        ST_WAIT = 3'd2,
        ST_RX   = 3'd3,
        ST_GAP  = 3'd4
    } state_t;

    // Serial CRC7 (x^7 + x^3 + 1, init 0). Leading zeros leave a zero CRC
    // untouched, so shorter messages are passed in zero-extended.
    function automatic logic [6:0] crc7_120(input logic [119:0] data);
        logic [6:0] crc;
        logic       fb;
        crc = 7'd0;
        for (int i = 119; i >= 0; i--) begin
            fb  = data[i] ^ crc[6];
            crc = {crc[5:0], 1'b0} ^ {3'b000, fb, 2'b00, fb};
        end
        return crc;
    endfunction

    state_t          r_state;
    logic [DIVW-1:0] r_div_cnt;
    logic            r_sd_clk;
    logic            r_cmd_out;
    logic            r_cmd_oe;
    logic            r_busy;
    logic            r_done;
    logic [1:0]      r_type;
    logic [5:0]      r_cmd_index;
    logic [47:0]     r_tx_sh;
    logic [7:0]      r_bit_cnt;
    logic [NCR_W-1:0] r_ncr_cnt;
    logic [GAP_W-1:0] r_gap_cnt;
    logic [132:0]    r_rx_sh;
    logic [5:0]      r_resp_index;
    logic [127:0]    r_resp_data;
    logic            r_err_timeout;
    logic            r_err_crc;
    logic            r_err_end;
    logic            r_err_index;

    logic            w_tick;
    logic            w_fall;
    logic            w_rise;
    logic [DIVW-1:0] w_div_load;
    logic [6:0]      w_tx_crc;
    logic [7:0]      w_rx_last;
    logic [133:0]    w_frame;
    logic [6:0]      w_rx_crc;
    logic            w_crc_bad;

    assign w_tick     = (r_div_cnt == {DIVW{1'b0}});
    assign w_fall     = w_tick & r_sd_clk;
    assign w_rise     = w_tick & ~r_sd_clk;
    assign w_div_load = (clk_div == {DIVW{1'b0}}) ? {DIVW{1'b0}} : (clk_div - DIVW'(1));
    assign w_tx_crc   = crc7_120({80'd0, 2'b01, cmd_index, cmd_arg});
    assign w_rx_last  = (r_type == 2'd3) ? 8'd135 : 8'd47;
    // Received bits 133..0 including the one being sampled this clk.
    assign w_frame    = {r_rx_sh, sd_cmd_in};
    assign w_rx_crc   = (r_type == 2'd3) ? crc7_120(w_frame[127:8])
                                         : crc7_120({80'd0, w_frame[47:8]});
    assign w_crc_bad  = (w_rx_crc != w_frame[7:1]);

    // sd_clk divider: toggle whenever the down-counter hits zero, reloading
    // from the current clk_div so a new ratio applies from the next half-period.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_div_cnt <= {DIVW{1'b0}};
            r_sd_clk  <= 1'b0;
        end else if (w_tick) begin
            r_div_cnt <= w_div_load;
            r_sd_clk  <= ~r_sd_clk;
        end else begin
            r_div_cnt <= r_div_cnt - DIVW'(1);
        end
    end

    // Transaction FSM: command TX on falls, response wait/RX on rises, idle gap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_cmd_out     <= 1'b1;
            r_cmd_oe      <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_type        <= 2'd0;
            r_cmd_index   <= 6'd0;
            r_tx_sh       <= 48'd0;
            r_bit_cnt     <= 8'd0;
            r_ncr_cnt     <= {NCR_W{1'b0}};
            r_gap_cnt     <= {GAP_W{1'b0}};
            r_rx_sh       <= 133'd0;
            r_resp_index  <= 6'd0;
            r_resp_data   <= 128'd0;
            r_err_timeout <= 1'b0;
            r_err_crc     <= 1'b0;
            r_err_end     <= 1'b0;
            r_err_index   <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_type        <= resp_type;
                        r_cmd_index   <= cmd_index;
                        r_tx_sh       <= {2'b01, cmd_index, cmd_arg, w_tx_crc, 1'b1};
                        r_bit_cnt     <= 8'd0;
                        r_ncr_cnt     <= {NCR_W{1'b0}};
                        r_gap_cnt     <= {GAP_W{1'b0}};
                        r_err_timeout <= 1'b0;
                        r_err_crc     <= 1'b0;
                        r_err_end     <= 1'b0;
                        r_err_index   <= 1'b0;
                        r_busy        <= 1'b1;
                        r_state       <= ST_TX;
                    end
                end
                ST_TX: begin
                    if (w_fall) begin
                        if (r_bit_cnt == 8'd48) begin
                            // Fall after the end bit: release the line.
                            r_cmd_out <= 1'b1;
                            r_cmd_oe  <= 1'b0;
                            r_state   <= (r_type == 2'd0) ? ST_GAP : ST_WAIT;
                        end else begin
                            r_cmd_out <= r_tx_sh[47];
                            r_cmd_oe  <= 1'b1;
                            r_tx_sh   <= {r_tx_sh[46:0], 1'b1};
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end
                ST_WAIT: begin
                    if (w_rise) begin
                        if (!sd_cmd_in) begin
                            r_rx_sh   <= 133'd0;
                            r_bit_cnt <= 8'd1;
                            r_state   <= ST_RX;
                        end else if (r_ncr_cnt == NCR_W'(NCR_MAX - 1)) begin
                            r_err_timeout <= 1'b1;
                            r_state       <= ST_GAP;
                        end else begin
                            r_ncr_cnt <= r_ncr_cnt + NCR_W'(1);
                        end
                    end
                end
                ST_RX: begin
                    if (w_rise) begin
                        r_rx_sh <= w_frame[132:0];
                        if (r_bit_cnt == w_rx_last) begin
                            if (r_type == 2'd3) begin
                                r_resp_index <= w_frame[133:128];
                                r_resp_data  <= w_frame[127:0];
                            end else begin
                                r_resp_index <= w_frame[45:40];
                                r_resp_data  <= {96'd0, w_frame[39:8]};
                            end
                            r_err_end   <= ~w_frame[0];
                            r_err_crc   <= (r_type != 2'd2) & w_crc_bad;
                            r_err_index <= (r_type == 2'd1) & (w_frame[45:40] != r_cmd_index);
                            r_state     <= ST_GAP;
                        end else begin
                            r_bit_cnt <= r_bit_cnt + 8'd1;
                        end
                    end
                end
                ST_GAP: begin
                    // Count sd_clk edges so the gap is NCC whole periods
                    // regardless of whether it was entered on a rise or fall.
                    if (w_tick) begin
                        if (r_gap_cnt == GAP_W'(2 * NCC - 1)) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= ST_IDLE;
                        end else begin
                            r_gap_cnt <= r_gap_cnt + GAP_W'(1);
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign resp_index  = r_resp_index;
    assign resp_data   = r_resp_data;
    assign err_timeout = r_err_timeout;
    assign err_crc     = r_err_crc;
    assign err_end     = r_err_end;
    assign err_index   = r_err_index;
    assign sd_clk      = r_sd_clk;
    assign sd_cmd_out  = r_cmd_out;
    assign sd_cmd_oe   = r_cmd_oe;

endmodule

// File: doc/sd_cmd_engine.md
Name: sd_cmd_engine

Overview:
- Parametrised SD-bus command-line engine.
- Generates sd_clk from the system clock with a runtime-programmable divider.
- Serialises a 48-bit command with a hardware CRC7, then receives and checks an R48 or R136 response, with timeout.
- Sits between the SD host controller's ring/descriptor logic and the card pins; the data-line engine is a separate block.

Parameters:
- DIVW, 8: width of the clock-divider (half-period) register.
- NCR_MAX, 64: max sd_clk rising edges, after the command end bit, to wait for a response start bit.
- NCC, 8: idle sd_clk cycles inserted after each transaction before done.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- clk_div  input  DIVW  sd_clk half-period in clk cycles; 0 is treated as 1
- start  input  1  one-cycle request; accepted only when busy=0
- cmd_index  input  6  command index
- cmd_arg  input  32  command argument
- resp_type  input  2  0 none, 1 R48 with CRC/index check, 2 R48 unchecked (R3), 3 R136
- busy  output  1  transaction in progress
- done  output  1  one-cycle completion pulse
- resp_index  output  6  received index field (R48)
- resp_data  output  128  R48: [31:0] = argument field, upper bits 0; R136: received bits 127..0
- err_timeout  output  1  no start bit within NCR_MAX
- err_crc  output  1  CRC7 mismatch
- err_end  output  1  end bit was 0
- err_index  output  1  R48 index differs from cmd_index (type 1 only)
- sd_clk  output  1  card clock
- sd_cmd_out  output  1  command-line drive value
- sd_cmd_oe  output  1  1 = drive the command line
- sd_cmd_in  input  1  command-line sampled value (pad-synchronised externally)

Behaviour:
- Reset values: sd_clk=0, sd_cmd_out=1, sd_cmd_oe=0, busy=0, done=0, all err_*=0, resp_index=0, resp_data=0, divider count=0, state IDLE.
- Clock generation:
  - Divider counter loads max(clk_div,1)-1 and decrements each clk.
  - At 0, sd_clk toggles and the counter reloads.
  - sd_clk runs continuously out of reset.
  - clk_div is re-read at every reload, so a change takes effect within one half-period without a glitch.
- Edge timing: "fall" = the clk on which sd_clk toggles 1->0; "rise" = the clk on which it toggles 0->1. Outputs change only on fall; sd_cmd_in is sampled only on rise.
- Start: in IDLE with start=1, latch cmd_index, cmd_arg and resp_type; clear all err_*; set busy=1 the next clk. start while busy is ignored.
- TX: 48 bits MSB-first, one per fall: 0, 1, index[5:0], arg[31:0], crc7[6:0], 1.
  - CRC7 uses polynomial x^7+x^3+1, init 0, computed serially over the first 40 bits.
  - sd_cmd_oe=1 from the first bit's fall through the end bit's period.
  - At the fall after the end bit: sd_cmd_oe=0, sd_cmd_out=1.
- Type 0: go to GAP.
- WAIT: count rises. The first rise sampling 0 starts RX. If NCR_MAX rises pass without a 0: err_timeout=1, go to GAP.
- RX: shift in the remaining 47 (R48) or 135 (R136) bits on rises.
  - R48 CRC covers bits 47..8.
  - R136 CRC covers bits 127..8; bits 135..128 are not checked.
  - err_end is set if the last bit is 0.
  - For types 2 and 3, err_index is never set; for type 2, err_crc is never set.
  - resp_index and resp_data update when the last bit is sampled.
- GAP: NCC full sd_clk periods with the line released. Then pulse done for one clk, busy=0 the same clk, return to IDLE.
- err_* and resp_* hold until the next accepted start.
- Async reset mid-transaction: immediately sd_cmd_oe=0, sd_clk=0, busy=0; no done pulse.

Test Plan:
- clk_div=2, start CMD0 (index 0, arg 0, type 0) -> line carries 48'h400000000095 MSB-first, each bit changing on an sd_clk fall; done pulse after 48+8 sd_clk periods; busy falls with done; no errors.
- CMD8 arg 32'h000001AA, type 1; card model replies 48'h08000001AA13 three clocks after the end bit -> TX frame 48'h48000001AA87; resp_index=8, resp_data[31:0]=32'h000001AA, all err_*=0.
- Type 1, card silent -> err_timeout=1 after exactly 64 rises; done after NCC more periods; err_crc=err_end=err_index=0.
- Type 1 reply with one CRC bit flipped and index 9 -> err_crc=1, err_index=1. The same corrupted reply with type 2 -> no errors.
- Type 3; card sends a 136-bit R2 with valid CRC over bits 127..8 -> resp_data matches the sent bits 127..0, no errors. Forcing the end bit to 0 -> err_end=1.
- Change clk_div 2->5 mid-idle, then assert rst_n=0 during TX -> half-period becomes 5 clks within one period; on reset, sd_cmd_oe=0, busy=0, sd_clk=0 immediately; no done pulse.
